// File: rtl/softmax_pkg.sv
// Shared Q-format constants, FSM state encoding and width helpers for the softmax engine.
package softmax_pkg;

  localparam int FRAC_DEF = 8;
  localparam int DW_DEF   = 16;
  localparam int ONE      = 1 << FRAC_DEF;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SUM  = 2'd1,
    DIV  = 2'd2,
    OUT  = 2'd3
  } state_t;

  // Accumulator width: one full-scale exponential per element, no saturation.
  function automatic int sum_width(input int frac, input int lanes, input int beats);
    return frac + 1 + $clog2(lanes * beats);
  endfunction

  // Reciprocal width: floor(2^(3*frac) / S) with S >= 2^frac fits here.
  function automatic int rcp_width(input int frac);
    return 2 * frac + 1;
  endfunction

endpackage

// File: rtl/softmax_stream_pow2_approx.sv
// Per-lane base-2 exponential approximation: e = (ONE - f/2) >> min(q, FRAC+1).
module pow2_approx
  import softmax_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic [DW:0]   a,
  input  logic          lane_en,
  output logic [FRAC:0] e
);

  localparam int QW = DW + 1 - FRAC;

  logic [QW-1:0]   q;
  logic [FRAC-1:0] f;
  logic [FRAC-1:0] half_f;
  logic [FRAC:0]   base;

  assign q      = a[DW:FRAC];
  assign f      = a[FRAC-1:0];
  assign half_f = f >> 1;
  assign base   = {1'b1, {FRAC{1'b0}}} - {1'b0, half_f};

  // Masked lanes and shifts past FRAC+1 both collapse to zero.
  always_comb begin
    e = '0;
    if (lane_en && (q <= QW'(FRAC + 1))) begin
      e = base >> q;
    end
  end

endmodule

// File: rtl/softmax_stream.sv
// Streaming softmax: buffer + running max, exponential sum, restoring reciprocal, normalised output.
module softmax_stream
  import softmax_pkg::*;
#(
  parameter int N        = 8,
  parameter int DW       = DW_DEF,
  parameter int FRAC     = FRAC_DEF,
  parameter int MAXBEATS = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] in_x_flat,
  input  logic [N-1:0]    in_mask,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*DW-1:0] out_prob_flat,
  output logic            out_last,
  output logic            overflow
);

  localparam int SW    = sum_width(FRAC, N, MAXBEATS);
  localparam int RW    = rcp_width(FRAC);
  localparam int AW    = (MAXBEATS > 1) ? $clog2(MAXBEATS) : 1;
  localparam int BW    = AW + 1;
  localparam int CW    = $clog2(RW);
  localparam int PW    = FRAC + 1 + RW;
  localparam int ONE_Q = 1 << FRAC;

  state_t state_q, state_d;

  logic [N*DW-1:0]      buf_x [MAXBEATS];
  logic [N-1:0]         buf_m [MAXBEATS];
  logic [BW-1:0]        wp, b_len, rp;
  logic signed [DW-1:0] max_q, max_d;
  logic [SW-1:0]        s_q, row_sum;
  logic [SW:0]          rem_q;
  logic [SW+1:0]        trial;
  logic                 q_bit;
  logic [RW-1:0]        quo_q;
  logic [CW-1:0]        div_cnt;
  logic                 ovf_q;
  logic                 accept, last_beat, row_last, out_fire, div_done;
  logic [N*DW-1:0]      row_x;
  logic [N-1:0]         row_m;
  logic [FRAC:0]        lane_e [N];

  assign in_ready  = en && (state_q == LOAD);
  assign accept    = in_valid && in_ready;
  assign last_beat = in_last || (wp == BW'(MAXBEATS - 1));
  assign row_last  = (rp == b_len - BW'(1));
  assign out_fire  = en && out_ready && (state_q == OUT);
  assign div_done  = (div_cnt == CW'(2 * FRAC));

  assign row_x = buf_x[rp[AW-1:0]];
  assign row_m = buf_m[rp[AW-1:0]];

  assign trial = {rem_q, 1'b0} - {2'b00, s_q};
  assign q_bit = ~trial[SW+1];

  assign out_valid = (state_q == OUT);
  assign out_last  = out_valid && row_last;
  assign overflow  = ovf_q;

  // Running maximum over the unmasked lanes of the incoming beat.
  always_comb begin
    max_d = max_q;
    for (int i = 0; i < N; i++) begin
      if (in_mask[i] && ($signed(in_x_flat[i*DW +: DW]) > max_d)) begin
        max_d = in_x_flat[i*DW +: DW];
      end
    end
  end

  // Exponentials shared by the SUM and OUT passes, plus the per-lane normalised output.
  for (genvar g = 0; g < N; g++) begin : g_lane
    logic signed [DW-1:0] lane_x;
    logic [DW:0]          lane_a;
    logic [PW-1:0]        prod;
    logic [PW-1:0]        scaled;

    assign lane_x = row_x[g*DW +: DW];
    assign lane_a = {max_q[DW-1], max_q} - {lane_x[DW-1], lane_x};

    pow2_approx #(.DW(DW), .FRAC(FRAC)) u_pow2 (
      .a       (lane_a),
      .lane_en (row_m[g]),
      .e       (lane_e[g])
    );

    assign prod   = PW'(lane_e[g]) * PW'(quo_q);
    assign scaled = prod >> (2 * FRAC);
    assign out_prob_flat[g*DW +: DW] = (state_q != OUT)           ? '0 :
                                       (scaled > PW'(ONE_Q))      ? DW'(ONE_Q) :
                                                                    scaled[DW-1:0];
  end

  // Lane sum of the row currently addressed by rp.
  always_comb begin
    row_sum = '0;
    for (int i = 0; i < N; i++) begin
      row_sum = row_sum + SW'(lane_e[i]);
    end
  end

  // State register; en=0 freezes the FSM, reset always wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
    end else if (en) begin
      state_q <= state_d;
    end
  end

  // Next-state logic for LOAD -> SUM -> DIV -> OUT -> LOAD.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (accept && last_beat) state_d = SUM;
      SUM:     if (row_last)            state_d = DIV;
      DIV:     if (div_done)            state_d = OUT;
      OUT:     if (out_fire && row_last) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // Vector buffer; contents need no reset since wp gates what is read back.
  always_ff @(posedge clk) begin
    if (accept) begin
      buf_x[wp[AW-1:0]] <= in_x_flat;
      buf_m[wp[AW-1:0]] <= in_mask;
    end
  end

  // Pointers, max, sum, divider and overflow flag, advanced per state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp      <= '0;
      b_len   <= '0;
      rp      <= '0;
      max_q   <= {1'b1, {(DW-1){1'b0}}};
      s_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      div_cnt <= '0;
      ovf_q   <= 1'b0;
    end else if (en) begin
      case (state_q)
        LOAD: begin
          if (accept) begin
            wp    <= wp + BW'(1);
            max_q <= max_d;
            if (last_beat) begin
              b_len <= wp + BW'(1);
              rp    <= '0;
              if (!in_last) ovf_q <= 1'b1;
            end
          end
        end
        SUM: begin
          s_q <= s_q + row_sum;
          if (row_last) begin
            rp      <= '0;
            rem_q   <= (SW+1)'(1) << (FRAC - 1);
            quo_q   <= '0;
            div_cnt <= '0;
          end else begin
            rp <= rp + BW'(1);
          end
        end
        DIV: begin
          div_cnt <= div_cnt + CW'(1);
          rem_q   <= q_bit ? trial[SW:0] : {rem_q[SW-1:0], 1'b0};
          if (div_done && (s_q == '0)) begin
            quo_q <= '1;
          end else begin
            quo_q <= {quo_q[RW-2:0], q_bit};
          end
        end
        OUT: begin
          if (out_fire) begin
            if (row_last) begin
              rp    <= '0;
              wp    <= '0;
              s_q   <= '0;
              max_q <= {1'b1, {(DW-1){1'b0}}};
              ovf_q <= 1'b0;
            end else begin
              rp <= rp + BW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_softmax_stream.sv
// Directed, scoreboard-based bench for softmax_stream with N=4, FRAC=8, MAXBEATS=4.
module tb_softmax_stream;
  import softmax_pkg::*;

  localparam int N_T   = 4;
  localparam int DW_T  = 16;
  localparam int FR_T  = FRAC_DEF;
  localparam int MB_T  = 4;
  localparam int LAT_T = 2 * FR_T + 2;

  logic                 clk = 1'b0;
  logic                 rst, en, in_valid, in_ready, in_last;
  logic                 out_valid, out_ready, out_last, overflow;
  logic [N_T*DW_T-1:0]  in_x_flat, out_prob_flat;
  logic [N_T-1:0]       in_mask;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct packed {
    logic [63:0] prob;
    logic        last;
    logic        ovf;
  } exp_t;

  exp_t sb[$];

  softmax_stream #(.N(N_T), .DW(DW_T), .FRAC(FR_T), .MAXBEATS(MB_T)) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_x_flat     (in_x_flat),
    .in_mask       (in_mask),
    .in_last       (in_last),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_prob_flat (out_prob_flat),
    .out_last      (out_last),
    .overflow      (overflow)
  );

  // Free-running clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] pack4(input int l0, input int l1, input int l2, input int l3);
    logic [63:0] v;
    v[15:0]  = l0[15:0];
    v[31:16] = l1[15:0];
    v[47:32] = l2[15:0];
    v[63:48] = l3[15:0];
    return v;
  endfunction

  function automatic int model_e(input int mx, input int x, input bit m);
    int a, q, f;
    if (!m) return 0;
    a = mx - x;
    q = a / ONE;
    f = a % ONE;
    if (q > FR_T + 1) return 0;
    return (ONE - f / 2) >> q;
  endfunction

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [63:0] prob, input logic last, input logic ovf);
    exp_t ex;
    ex.prob = prob;
    ex.last = last;
    ex.ovf  = ovf;
    sb.push_back(ex);
  endtask

  task automatic apply_stimulus(input logic [63:0] x, input logic [3:0] m, input logic last,
                                output int acc_cyc);
    int w;
    w         = 0;
    in_valid  = 1'b1;
    in_x_flat = x;
    in_mask   = m;
    in_last   = last;
    while (in_ready !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    check_val("accept_ready", in_ready, 1);
    acc_cyc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_output(input string tag, input int stall, output int seen);
    exp_t ex;
    int   w;
    w = 0;
    while (out_valid !== 1'b1 && w < 300) begin
      @(negedge clk);
      w++;
    end
    seen = cyc;
    check_val({tag, "_valid"}, out_valid, 1);
    if (sb.size() > 0) ex = sb.pop_front();
    else               ex = '1;
    for (int k = 0; k < stall; k++) begin
      out_ready = 1'b0;
      check_val({tag, "_stall_valid"}, out_valid, 1);
      check_val({tag, "_stall_prob"}, out_prob_flat, ex.prob);
      check_val({tag, "_stall_last"}, out_last, ex.last);
      @(negedge clk);
    end
    out_ready = 1'b1;
    check_val({tag, "_prob"}, out_prob_flat, ex.prob);
    check_val({tag, "_last"}, out_last, ex.last);
    check_val({tag, "_ovf"}, overflow, ex.ovf);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  // Directed stimulus sequence
  initial begin
    int t_acc, seen, w, mx, s, r, pv;
    int mdl_x [3][4];
    logic [3:0] mdl_m [3];
    int e [3][4];
    int p [4];

    rst = 1'b1; en = 1'b1; in_valid = 1'b0; in_x_flat = '0;
    in_mask = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    $display("[TB] reset state");
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_prob", out_prob_flat, 0);
    check_val("rst_out_last", out_last, 0);
    check_val("rst_overflow", overflow, 0);
    check_val("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] single zero beat");
    push_exp(pack4(64, 64, 64, 64), 1'b1, 1'b0);
    apply_stimulus(pack4(0, 0, 0, 0), 4'hF, 1'b1, t_acc);
    check_output("zero1", 0, seen);
    check_val("zero1_latency", seen - t_acc, 1 + LAT_T);
    check_val("zero1_idle", out_valid, 0);

    $display("[TB] spread beat");
    push_exp(pack4(146, 73, 36, 0), 1'b1, 1'b0);
    apply_stimulus(pack4(256, 0, -256, -2048), 4'hF, 1'b1, t_acc);
    check_output("spread", 0, seen);

    $display("[TB] masked beat");
    push_exp(pack4(109, 146, 0, 0), 1'b1, 1'b0);
    apply_stimulus(pack4(-128, 0, 0, 0), 4'b0011, 1'b1, t_acc);
    check_output("masked", 0, seen);

    $display("[TB] two beats with backpressure");
    push_exp(pack4(32, 32, 32, 32), 1'b0, 1'b0);
    push_exp(pack4(32, 32, 32, 32), 1'b1, 1'b0);
    apply_stimulus(pack4(0, 0, 0, 0), 4'hF, 1'b0, t_acc);
    apply_stimulus(pack4(0, 0, 0, 0), 4'hF, 1'b1, t_acc);
    check_output("two_a", 5, seen);
    check_output("two_b", 0, seen);
    check_val("two_done_valid", out_valid, 0);
    check_val("two_done_ready", in_ready, 1);

    $display("[TB] truncation");
    for (int b = 0; b < MB_T; b++) push_exp(pack4(16, 16, 16, 16), b == MB_T - 1, 1'b1);
    for (int b = 0; b < MB_T; b++) apply_stimulus(pack4(0, 0, 0, 0), 4'hF, 1'b0, t_acc);
    for (int b = 0; b < MB_T; b++) check_output("trunc", 0, seen);
    push_exp(pack4(64, 64, 64, 64), 1'b1, 1'b0);
    apply_stimulus(pack4(0, 0, 0, 0), 4'hF, 1'b1, t_acc);
    check_output("after_trunc", 0, seen);

    $display("[TB] enable stall during divide");
    push_exp(pack4(146, 73, 36, 0), 1'b1, 1'b0);
    apply_stimulus(pack4(256, 0, -256, -2048), 4'hF, 1'b1, t_acc);
    repeat (4) @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    en = 1'b1;
    check_output("en_stall", 0, seen);
    check_val("en_stall_latency", seen - t_acc, 1 + LAT_T + 3);

    $display("[TB] three-beat model vector");
    mdl_x = '{'{100, -300, 50, 700}, '{-1000, 650, 0, 30000}, '{640, 512, -32768, 699}};
    mdl_m = '{4'b1111, 4'b0111, 4'b1011};
    mx = -32768;
    for (int b = 0; b < 3; b++)
      for (int l = 0; l < 4; l++)
        if (mdl_m[b][l] && mdl_x[b][l] > mx) mx = mdl_x[b][l];
    s = 0;
    for (int b = 0; b < 3; b++)
      for (int l = 0; l < 4; l++) begin
        e[b][l] = model_e(mx, mdl_x[b][l], mdl_m[b][l]);
        s += e[b][l];
      end
    r = (s == 0) ? (1 << (2 * FR_T + 1)) - 1 : (1 << (3 * FR_T)) / s;
    for (int b = 0; b < 3; b++) begin
      for (int l = 0; l < 4; l++) begin
        pv   = (e[b][l] * r) >> (2 * FR_T);
        p[l] = (pv > ONE) ? ONE : pv;
      end
      push_exp(pack4(p[0], p[1], p[2], p[3]), b == 2, 1'b0);
    end
    for (int b = 0; b < 3; b++)
      apply_stimulus(pack4(mdl_x[b][0], mdl_x[b][1], mdl_x[b][2], mdl_x[b][3]),
                     mdl_m[b], b == 2, t_acc);
    check_output("model_b0", 0, seen);
    check_output("model_b1", 2, seen);
    check_output("model_b2", 1, seen);

    $display("[TB] reset during output");
    apply_stimulus(pack4(0, 0, 0, 0), 4'hF, 1'b1, t_acc);
    w = 0;
    while (out_valid !== 1'b1 && w < 300) begin
      @(negedge clk);
      w++;
    end
    check_val("rstout_pre_valid", out_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    check_val("rstout_valid", out_valid, 0);
    check_val("rstout_prob", out_prob_flat, 0);
    check_val("rstout_last", out_last, 0);
    check_val("rstout_ovf", overflow, 0);
    check_val("rstout_ready", in_ready, 1);
    rst = 1'b0;
    @(negedge clk);
    check_val("rstout_post_valid", out_valid, 0);
    push_exp(pack4(64, 64, 64, 64), 1'b1, 1'b0);
    apply_stimulus(pack4(0, 0, 0, 0), 4'hF, 1'b1, t_acc);
    check_output("post_rst", 0, seen);
    check_val("post_rst_latency", seen - t_acc, 1 + LAT_T);

    check_val("sb_leftover", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
